// File: rtl/signal_sync_bank_if.sv
// Bundle of the per-channel async inputs and the synchronised outputs.
interface signal_sync_bank_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] async_in;
    logic [NCH-1:0] sync_out;
    logic [NCH-1:0] rise_pls;
    logic [NCH-1:0] fall_pls;
    logic           chg_any;

    modport master (
        output async_in,
        input  sync_out,
        input  rise_pls,
        input  fall_pls,
        input  chg_any
    );

    modport slave (
        input  async_in,
        output sync_out,
        output rise_pls,
        output fall_pls,
        output chg_any
    );
endinterface

// File: rtl/signal_sync_bank.sv
// Multi-channel level synchroniser with an optional per-channel glitch filter.
// The filter also produces one-cycle rise/fall pulses.
// Quasi-static single-bit controls only; bits of a bus are not kept coherent.
module signal_sync_bank #(
    parameter int             NCH      = 4,
    parameter int             STAGES   = 3,
    parameter logic [NCH-1:0] RST_VAL  = {NCH{1'b1}},
    parameter int             FILT_W   = 4,
    parameter int             FILT_LEN = 0
) (
    input  logic                clk,
    input  logic                rstn,
    signal_sync_bank_if.slave   sb
);

    // FILT_LEN 0 and 1 both update on the first disagreeing edge.
    localparam int                TC_INT = (FILT_LEN > 1) ? FILT_LEN - 1 : 0;
    localparam logic [FILT_W-1:0] TC     = FILT_W'(TC_INT);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("signal_sync_bank: STAGES must be in 2..4");
    end
    if (FILT_LEN >= (1 << FILT_W)) begin : g_bad_filt
        $error("signal_sync_bank: FILT_LEN must be below 2**FILT_W");
    end

    (* async_reg = "true" *) logic [NCH-1:0] r_chain [STAGES];
    logic [NCH-1:0] w_raw;
    logic [NCH-1:0] w_upd;
    logic [NCH-1:0] r_sync;
    logic [NCH-1:0] r_rise;
    logic [NCH-1:0] r_fall;
    logic           r_chg;

    // Plain flop chain, nothing between stages.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < STAGES; s++) r_chain[s] <= RST_VAL;
        end else begin
            r_chain[0] <= sb.async_in;
            for (int s = 1; s < STAGES; s++) r_chain[s] <= r_chain[s-1];
        end
    end

    assign w_raw = r_chain[STAGES-1];

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [FILT_W-1:0] r_cnt;

        // Sync_out takes raw once raw has disagreed for the terminal count of edges.
        assign w_upd[ch] = (w_raw[ch] != r_sync[ch]) && (r_cnt == TC);

        // Count consecutive disagreeing cycles; any agreement restarts the count.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_cnt <= '0;
            end else if (w_raw[ch] == r_sync[ch] || r_cnt == TC) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Output level and edge pulses register together, so each pulse lands in the cycle the level changes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= RST_VAL;
            r_rise <= '0;
            r_fall <= '0;
            r_chg  <= 1'b0;
        end else begin
            r_sync <= r_sync ^ w_upd;
            r_rise <= w_upd & w_raw;
            r_fall <= w_upd & ~w_raw;
            r_chg  <= |w_upd;
        end
    end

    assign sb.sync_out = r_sync;
    assign sb.rise_pls = r_rise;
    assign sb.fall_pls = r_fall;
    assign sb.chg_any  = r_chg;

endmodule

// File: tb/tb_signal_sync_bank.sv
// Directed bench: four instances cover bypass/2-stage/filtered/mixed reset values.
module tb_signal_sync_bank;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    signal_sync_bank_if #(.NCH(4)) if_a ();
    signal_sync_bank_if #(.NCH(4)) if_b ();
    signal_sync_bank_if #(.NCH(4)) if_c ();
    signal_sync_bank_if #(.NCH(4)) if_d ();

    signal_sync_bank #(.NCH(4), .STAGES(3), .RST_VAL(4'hF), .FILT_W(4), .FILT_LEN(0))
        dut_a (.clk(clk), .rstn(rstn), .sb(if_a.slave));
    signal_sync_bank #(.NCH(4), .STAGES(2), .RST_VAL(4'hF), .FILT_W(4), .FILT_LEN(0))
        dut_b (.clk(clk), .rstn(rstn), .sb(if_b.slave));
    signal_sync_bank #(.NCH(4), .STAGES(3), .RST_VAL(4'h0), .FILT_W(4), .FILT_LEN(4))
        dut_c (.clk(clk), .rstn(rstn), .sb(if_c.slave));
    signal_sync_bank #(.NCH(4), .STAGES(3), .RST_VAL(4'hA), .FILT_W(4), .FILT_LEN(0))
        dut_d (.clk(clk), .rstn(rstn), .sb(if_d.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        if_a.async_in = 4'hF;
        if_b.async_in = 4'hF;
        if_c.async_in = 4'h0;
        if_d.async_in = 4'h5;
        rstn = 1'b0;
        tick(2);
        chk("rst_a_sync", if_a.sync_out, 4'hF);
        chk("rst_a_pls",  {if_a.rise_pls, if_a.fall_pls, 3'b0, if_a.chg_any}, 12'h000);
        chk("rst_c_sync", if_c.sync_out, 4'h0);
        chk("rst_d_sync", if_d.sync_out, 4'hA);
        rstn = 1'b1;

        // T1 idle after release, T6 runs alongside on dut_d
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk("t1_idle_sync", if_a.sync_out, 4'hF);
            chk("t1_idle_pls",  {if_a.rise_pls, if_a.fall_pls, 3'b0, if_a.chg_any}, 12'h000);
            chk("t2_idle_sync", if_b.sync_out, 4'hF);
            chk("t6_sync", if_d.sync_out, (i < 4) ? 4'hA : 4'h5);
            chk("t6_rise", if_d.rise_pls, (i == 4) ? 4'h5 : 4'h0);
            chk("t6_fall", if_d.fall_pls, (i == 4) ? 4'hA : 4'h0);
            chk("t6_chg",  if_d.chg_any,  (i == 4) ? 1'b1 : 1'b0);
        end

        // T1/T2: ch0 falls
        if_a.async_in = 4'hE;
        if_b.async_in = 4'hE;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            chk("t1_sync", if_a.sync_out, (i < 4) ? 4'hF : 4'hE);
            chk("t1_fall", if_a.fall_pls, (i == 4) ? 4'h1 : 4'h0);
            chk("t1_chg",  if_a.chg_any,  (i == 4) ? 1'b1 : 1'b0);
            chk("t2_sync", if_b.sync_out, (i < 3) ? 4'hF : 4'hE);
            chk("t2_fall", if_b.fall_pls, (i == 3) ? 4'h1 : 4'h0);
        end

        // T3: 3-cycle glitch on ch1 is rejected
        if_c.async_in = 4'h2;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (i == 3) if_c.async_in = 4'h0;
            chk("t3_glitch_sync", if_c.sync_out, 4'h0);
            chk("t3_glitch_rise", if_c.rise_pls, 4'h0);
        end
        // T3: held high passes after STAGES + FILT_LEN edges
        if_c.async_in = 4'h2;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            chk("t3_sync", if_c.sync_out, (i < 7) ? 4'h0 : 4'h2);
            chk("t3_rise", if_c.rise_pls, (i == 7) ? 4'h2 : 4'h0);
        end

        // T4: simultaneous rise on ch0 and ch2
        if_c.async_in = 4'h0;
        tick(10);
        chk("t4_settle", if_c.sync_out, 4'h0);
        if_c.async_in = 4'h5;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            chk("t4_sync", if_c.sync_out, (i < 7) ? 4'h0 : 4'h5);
            chk("t4_rise", if_c.rise_pls, (i == 7) ? 4'h5 : 4'h0);
            chk("t4_fall", if_c.fall_pls, 4'h0);
            chk("t4_chg",  if_c.chg_any,  (i == 7) ? 1'b1 : 1'b0);
        end

        // T5: reset during a pulse (dut_a) and during a filter count (dut_c)
        if_a.async_in = 4'hF;
        if_c.async_in = 4'h0;
        tick(10);
        if_a.async_in = 4'hE;
        if_c.async_in = 4'h2;
        tick(4);
        chk("t5_pre_fall", if_a.fall_pls, 4'h1);
        chk("t5_pre_csync", if_c.sync_out, 4'h0);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_a_sync", if_a.sync_out, 4'hF);
        chk("t5_rst_a_fall", if_a.fall_pls, 4'h0);
        chk("t5_rst_a_chg",  if_a.chg_any,  1'b0);
        chk("t5_rst_c_sync", if_c.sync_out, 4'h0);
        chk("t5_rst_d_sync", if_d.sync_out, 4'hA);
        tick(1);
        rstn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            chk("t5_a_sync", if_a.sync_out, (i < 4) ? 4'hF : 4'hE);
            chk("t5_a_fall", if_a.fall_pls, (i == 4) ? 4'h1 : 4'h0);
            chk("t5_c_sync", if_c.sync_out, (i < 7) ? 4'h0 : 4'h2);
            chk("t5_c_rise", if_c.rise_pls, (i == 7) ? 4'h2 : 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
